sme_match_collector: RTL

SME_MATCH_COLLECTOR -- requirements
Module: sme_match_collector

---
 rtl/sme_match_collector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sme_match_collector.sv
// sme_match_collector
//   Collects rule IDs reported by the SME match output into a first-word-
//   fall-through FIFO, and builds one descriptor per packet (number of IDs
//   stored, plus whether any were dropped for lack of FIFO space).
//   After the last beat of a packet the block stops accepting beats
//   (match_release=0) until the core acknowledges the descriptor.
//
// Parameters
//   FIFO_DEPTH : rule-ID FIFO entries (power of two, 4..256)
//   CNT_WIDTH  : width of the per-packet stored-ID counter
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   match_rules_ID  : rule ID of the current match beat (0 = filler)
//   match_last      : final beat of the packet
//   match_valid     : beat valid
//   match_release   : ready toward the SME (registered)
//   rd_id/rd_valid  : FIFO head and non-empty flag
//   rd_pop          : consume the FIFO head
//   desc_count      : IDs stored for the completed packet
//   desc_overflow   : some IDs of that packet were dropped
//   desc_valid      : descriptor pending
//   desc_ack        : consume the descriptor
//   drop_cnt        : total dropped IDs since reset, saturating
module sme_match_collector #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          match_rules_ID,
  input  logic                 match_last,
  input  logic                 match_valid,
  output logic                 match_release,
  output logic [31:0]          rd_id,
  output logic                 rd_valid,
  input  logic                 rd_pop,
  output logic [CNT_WIDTH-1:0] desc_count,
  output logic                 desc_overflow,
  output logic                 desc_valid,
  input  logic                 desc_ack,
  output logic [15:0]          drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {COLLECT, HOLD} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  state_t               state;
  logic [31:0]          mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic                 pkt_ovf;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 accept;
  logic                 id_nz;
  logic                 do_push;
  logic                 do_drop;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf_next;

  // The extra pointer bit tells full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = rd_pop & ~fifo_empty;
  // match_release is high exactly in COLLECT, so it doubles as the accept gate.
  assign accept  = match_valid & match_release;
  assign id_nz   = |match_rules_ID;
  // A full FIFO still takes the ID when the head leaves in the same cycle.
  assign do_push = accept & id_nz & (~fifo_full | do_pop);
  assign do_drop = accept & id_nz & ~do_push;

  assign cnt_next = do_push ? sat_inc_cnt(pkt_cnt) : pkt_cnt;
  assign ovf_next = pkt_ovf | do_drop;

  assign rd_valid   = ~fifo_empty;
  assign rd_id      = mem[rd_ptr[AW-1:0]];
  assign desc_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr[AW-1:0]] <= match_rules_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      match_release <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pkt_cnt       <= '0;
      pkt_ovf       <= 1'b0;
      desc_count    <= '0;
      desc_overflow <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (do_pop)  rd_ptr   <= rd_ptr + 1'b1;
      if (do_push) wr_ptr   <= wr_ptr + 1'b1;
      if (do_drop) drop_cnt <= sat_inc_drop(drop_cnt);

      case (state)
        COLLECT: begin
          if (accept && match_last) begin
            // Descriptor includes the closing beat itself.
            desc_count    <= cnt_next;
            desc_overflow <= ovf_next;
            pkt_cnt       <= '0;
            pkt_ovf       <= 1'b0;
            state         <= HOLD;
            match_release <= 1'b0;
          end else begin
            pkt_cnt <= cnt_next;
            pkt_ovf <= ovf_next;
          end
        end
        HOLD: begin
          if (desc_ack) begin
            state         <= COLLECT;
            match_release <= 1'b1;
          end
        end
        default: begin
          state         <= COLLECT;
          match_release <= 1'b1;
        end
      endcase
    end
  end

endmodule
